// File: rtl/cpu_storebuffer_coalesce_pkg.sv
// Shared types and helpers for the coalescing store buffer.
package cpu_storebuffer_coalesce_pkg;

  typedef enum logic [1:0] {
    ActIdle,
    ActAlloc,
    ActCoalesce
  } sb_action_e;

  function automatic int unsigned be_width(int unsigned data_width);
    return data_width / 8;
  endfunction

  // One byte lane of a masked merge: the new byte wins where its enable is set.
  function automatic logic [7:0] merge_byte(logic [7:0] old_byte, logic [7:0] new_byte,
                                            logic en);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/cpu_storebuffer_fwd_lane.sv
// One byte lane of load forwarding: picks the youngest matching entry's byte.
// Inputs are ordered oldest (index 0) to youngest (index SIZE-1).
module cpu_storebuffer_fwd_lane #(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0]   match,
  input  logic [SIZE*8-1:0] lane_bytes,
  output logic              hit,
  output logic [7:0]        data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Later (younger) matches override earlier ones.
    for (int unsigned k = 0; k < SIZE; k++) begin
      if (match[k]) begin
        hit  = 1'b1;
        data = lane_bytes[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/cpu_storebuffer_coalesce.sv
// Coalescing store buffer: FIFO of masked stores, byte forwarding, cache drain.
// Define CPU_STOREBUFFER_COALESCE_EN to merge same-tag pushes into the youngest entry.
module cpu_storebuffer_coalesce
  import cpu_storebuffer_coalesce_pkg::*;
#(
  parameter int unsigned SIZE       = 4,
  parameter int unsigned TAG_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned BE_WIDTH  = be_width(DATA_WIDTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  logic [TAG_WIDTH-1:0]      push_tag,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic [BE_WIDTH-1:0]       push_be,
  input  logic                      lookup_valid,
  input  logic [TAG_WIDTH-1:0]      lookup_tag,
  output logic                      lookup_hit,
  output logic [BE_WIDTH-1:0]       lookup_be,
  output logic [DATA_WIDTH-1:0]     lookup_data,
  output logic                      drain_valid,
  input  logic                      drain_ready,
  output logic [TAG_WIDTH-1:0]      drain_tag,
  output logic [DATA_WIDTH-1:0]     drain_data,
  output logic [BE_WIDTH-1:0]       drain_be,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(SIZE+1)-1:0] count
);

  localparam int unsigned PW = $clog2(SIZE);
  localparam int unsigned CW = $clog2(SIZE + 1);

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   be;
  } entry_t;

  entry_t                entry_q [SIZE];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  lk_hit_q;
  logic [BE_WIDTH-1:0]   lk_be_q;
  logic [DATA_WIDTH-1:0] lk_data_q;

  logic [PW-1:0]         young_idx;
  logic                  drain_fire;
  logic                  coalesce_ok;
  sb_action_e            act;
  logic [DATA_WIDTH-1:0] merged_data;
  logic [PW-1:0]         ord_idx [SIZE];
  logic [BE_WIDTH-1:0]   fwd_be;
  logic [DATA_WIDTH-1:0] fwd_data;

  function automatic logic [PW-1:0] ring_idx(logic [PW-1:0] base, int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= SIZE) s = s - SIZE;
    return PW'(s);
  endfunction

  function automatic logic [PW-1:0] ring_inc(logic [PW-1:0] p);
    return (p == PW'(SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(SIZE));
  assign count       = count_q;
  assign drain_valid = !empty && !reset;
  assign drain_tag   = entry_q[head_q].tag;
  assign drain_data  = entry_q[head_q].data;
  assign drain_be    = entry_q[head_q].be;
  assign lookup_hit  = lk_hit_q;
  assign lookup_be   = lk_be_q;
  assign lookup_data = lk_data_q;

  always_comb begin
    young_idx   = (tail_q == '0) ? PW'(SIZE - 1) : tail_q - 1'b1;
    drain_fire  = drain_valid && drain_ready;
    coalesce_ok = 1'b0;
`ifdef CPU_STOREBUFFER_COALESCE_EN
    // The youngest entry must survive this edge to absorb the push.
    coalesce_ok = push_valid && !empty && (entry_q[young_idx].tag == push_tag) &&
                  !((count_q == CW'(1)) && drain_fire);
`endif
    push_ready = coalesce_ok || !full;

    act = ActIdle;
    if (push_valid && push_ready) act = coalesce_ok ? ActCoalesce : ActAlloc;

    merged_data = '0;
    for (int unsigned b = 0; b < BE_WIDTH; b++) begin
      merged_data[8*b +: 8] = merge_byte(entry_q[young_idx].data[8*b +: 8],
                                         push_data[8*b +: 8], push_be[b]);
    end

    head_d  = drain_fire ? ring_inc(head_q) : head_q;
    tail_d  = (act == ActAlloc) ? ring_inc(tail_q) : tail_q;
    count_d = count_q;
    unique case ({act == ActAlloc, drain_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    for (int unsigned k = 0; k < SIZE; k++) ord_idx[k] = ring_idx(head_q, k);
  end

  for (genvar b = 0; b < BE_WIDTH; b++) begin : g_lane
    logic [SIZE-1:0]   lane_match;
    logic [SIZE*8-1:0] lane_bytes;

    always_comb begin
      lane_match = '0;
      lane_bytes = '0;
      for (int unsigned k = 0; k < SIZE; k++) begin
        lane_match[k] = entry_q[ord_idx[k]].valid && entry_q[ord_idx[k]].be[b] &&
                        (entry_q[ord_idx[k]].tag == lookup_tag);
        lane_bytes[8*k +: 8] = entry_q[ord_idx[k]].data[8*b +: 8];
      end
    end

    cpu_storebuffer_fwd_lane #(
      .SIZE(SIZE)
    ) u_lane (
      .match     (lane_match),
      .lane_bytes(lane_bytes),
      .hit       (fwd_be[b]),
      .data      (fwd_data[8*b +: 8])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < SIZE; i++) entry_q[i] <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      lk_hit_q  <= 1'b0;
      lk_be_q   <= '0;
      lk_data_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (drain_fire) entry_q[head_q].valid <= 1'b0;
      unique case (act)
        ActAlloc: begin
          entry_q[tail_q] <= '{valid: 1'b1, tag: push_tag, data: push_data, be: push_be};
        end
        ActCoalesce: begin
          entry_q[young_idx].data <= merged_data;
          entry_q[young_idx].be   <= entry_q[young_idx].be | push_be;
        end
        default: ;
      endcase
      if (lookup_valid) begin
        lk_hit_q  <= &fwd_be;
        lk_be_q   <= fwd_be;
        lk_data_q <= fwd_data;
      end else begin
        lk_hit_q  <= 1'b0;
        lk_be_q   <= '0;
        lk_data_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_storebuffer_coalesce.sv
// Scoreboard bench for cpu_storebuffer_coalesce: directed plan plus random traffic.
module tb_cpu_storebuffer_coalesce;

  localparam int SIZE = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        push_valid = 1'b0, push_ready;
  logic [15:0] push_tag = '0;
  logic [31:0] push_data = '0;
  logic [3:0]  push_be = '0;
  logic        lookup_valid = 1'b0;
  logic [15:0] lookup_tag = '0;
  logic        lookup_hit;
  logic [3:0]  lookup_be;
  logic [31:0] lookup_data;
  logic        drain_valid, drain_ready = 1'b0;
  logic [15:0] drain_tag;
  logic [31:0] drain_data;
  logic [3:0]  drain_be;
  logic        empty, full;
  logic [2:0]  count;

  cpu_storebuffer_coalesce dut (
    .clock       (clock),
    .reset       (reset),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_tag    (push_tag),
    .push_data   (push_data),
    .push_be     (push_be),
    .lookup_valid(lookup_valid),
    .lookup_tag  (lookup_tag),
    .lookup_hit  (lookup_hit),
    .lookup_be   (lookup_be),
    .lookup_data (lookup_data),
    .drain_valid (drain_valid),
    .drain_ready (drain_ready),
    .drain_tag   (drain_tag),
    .drain_data  (drain_data),
    .drain_be    (drain_be),
    .empty       (empty),
    .full        (full),
    .count       (count)
  );

  always #5 clock = ~clock;

  typedef struct {logic [15:0] tag; logic [31:0] data; logic [3:0] be;} ent_t;
  typedef struct {int cyc; logic rdy; int cnt;} st_t;
  typedef struct {int cyc; ent_t e;} dr_t;
  typedef struct {int cyc; logic [3:0] be; logic [31:0] data;} lk_t;

  ent_t mq[$];
  st_t  sq[$];
  dr_t  dq[$];
  lk_t  lq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   coal_en;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle of stimulus and predicts its outcome from the queue model.
  task automatic cycle(input logic pv, input logic [15:0] pt, input logic [31:0] pd,
                       input logic [3:0] pb, input logic lv, input logic [15:0] lt,
                       input logic dr);
    int   n;
    logic fire, coal, rdy;
    lk_t  l;
    ent_t e;
    @(posedge clock);
    #1;
    reset = 1'b0; push_valid = pv; push_tag = pt; push_data = pd; push_be = pb;
    lookup_valid = lv; lookup_tag = lt; drain_ready = dr;
    n    = mq.size();
    fire = (n > 0) && dr;
    coal = coal_en && pv && (n > 0) && (mq[n-1].tag == pt) && !(n == 1 && fire);
    rdy  = coal || (n < SIZE);
    sq.push_back('{cyc: cyc, rdy: rdy, cnt: n});
    l = '{cyc: cyc, be: 4'h0, data: 32'h0};
    if (lv) begin
      for (int b = 0; b < 4; b++)
        for (int k = 0; k < n; k++)
          if (mq[k].tag == lt && mq[k].be[b]) begin
            l.be[b] = 1'b1;
            l.data[8*b +: 8] = mq[k].data[8*b +: 8];
          end
    end
    lq.push_back(l);
    if (fire) begin
      dq.push_back('{cyc: cyc, e: mq[0]});
      void'(mq.pop_front());
    end
    if (pv && rdy) begin
      if (coal) begin
        e = mq[mq.size()-1];
        for (int b = 0; b < 4; b++) if (pb[b]) e.data[8*b +: 8] = pd[8*b +: 8];
        e.be = e.be | pb;
        mq[mq.size()-1] = e;
      end else begin
        mq.push_back('{tag: pt, data: pd, be: pb});
      end
    end
  endtask

  task automatic idle(input logic dr = 1'b0);
    cycle(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0, dr);
  endtask

  task automatic push(input logic [15:0] t, input logic [31:0] d, input logic [3:0] b,
                      input logic dr = 1'b0);
    cycle(1'b1, t, d, b, 1'b0, 16'h0, dr);
  endtask

  task automatic lookup(input logic [15:0] t);
    cycle(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, t, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1; push_valid = 1'b0; lookup_valid = 1'b0; drain_ready = 1'b1;
    mq.delete(); sq.delete(); dq.delete(); lq.delete();
    @(negedge clock);
    chk("reset_cycle_drain_valid", drain_valid, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents the matching output.
  always @(negedge clock) begin
    if (!reset) begin
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        st_t s;
        s = sq.pop_front();
        chk("push_ready", push_ready, s.rdy);
        chk("count", count, s.cnt);
        chk("empty", empty, s.cnt == 0);
        chk("full", full, s.cnt == SIZE);
        chk("drain_valid", drain_valid, s.cnt != 0);
      end
      if (drain_valid && drain_ready) begin
        if (dq.size() == 0 || dq[0].cyc != cyc) begin
          chk("unexpected_drain", 1, 0);
        end else begin
          dr_t d;
          d = dq.pop_front();
          chk("drain_tag", drain_tag, d.e.tag);
          chk("drain_data", drain_data, d.e.data);
          chk("drain_be", drain_be, d.e.be);
        end
      end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
        void'(dq.pop_front());
        chk("missing_drain", 0, 1);
      end
      while (lq.size() > 0 && lq[0].cyc < cyc) begin
        lk_t l;
        l = lq.pop_front();
        chk("lookup_be", lookup_be, l.be);
        chk("lookup_data", lookup_data, l.data);
        chk("lookup_hit", lookup_hit, l.be == 4'hF);
      end
    end
  end

  initial begin
`ifdef CPU_STOREBUFFER_COALESCE_EN
    coal_en = 1'b1;
`else
    coal_en = 1'b0;
`endif
    // 1: reset then idle
    do_reset();
    idle();
    @(negedge clock);
    chk("t1_empty", empty, 1);
    chk("t1_full", full, 0);
    chk("t1_count", count, 0);
    chk("t1_lookup_hit", lookup_hit, 0);

    // 2: partial stores to the same tag
    push(16'h10, 32'h0000_00AA, 4'b0001);
    push(16'h10, 32'h0000_BB00, 4'b0010);
    idle();
    @(negedge clock);
    chk("t2_count", count, coal_en ? 1 : 2);
    chk("t2_drain_data", drain_data, coal_en ? 32'h0000_BBAA : 32'h0000_00AA);
    chk("t2_drain_be", drain_be, coal_en ? 4'b0011 : 4'b0001);

    // 3: forwarding, partial then full coverage
    lookup(16'h10);
    idle();
    @(negedge clock);
    chk("t3_lookup_be", lookup_be, 4'b0011);
    chk("t3_lookup_data", lookup_data, 32'h0000_BBAA);
    chk("t3_lookup_hit", lookup_hit, 0);
    push(16'h10, 32'hDDCC_0000, 4'b1100);
    lookup(16'h10);
    idle();
    @(negedge clock);
    chk("t3_lookup_hit_full", lookup_hit, 1);
    chk("t3_lookup_data_full", lookup_data, 32'hDDCC_BBAA);
    repeat (4) idle(1'b1);
    idle();
    @(negedge clock);
    chk("t3_drained_empty", empty, 1);

    // 4: full behaviour
    for (int t = 1; t <= 4; t++) push(16'(t), 32'(t), 4'hF);
    push(16'h5, 32'h5, 4'hF);
    @(negedge clock);
    chk("t4_full", full, 1);
    chk("t4_refuse_new_tag", push_ready, 0);
    push(16'h4, 32'h44, 4'b0001);
    @(negedge clock);
    chk("t4_coalesce_at_full", push_ready, coal_en);
    push(16'h5, 32'h5, 4'hF, 1'b1);
    @(negedge clock);
    chk("t4_refuse_with_drain", push_ready, 0);

    // 5: FIFO order, then refill across the wrap point
    for (int t = 2; t <= 4; t++) begin
      idle(1'b1);
      @(negedge clock);
      chk("t5_drain_order", drain_tag, 16'(t));
    end
    idle();
    @(negedge clock);
    chk("t5_empty", empty, 1);
    for (int t = 0; t < 4; t++) push(16'h41 + 16'(t), 32'hA0 + 32'(t), 4'hF);
    idle();
    @(negedge clock);
    chk("t5_wrap_full", full, 1);
    repeat (4) idle(1'b1);

    // 6: youngest-wins forwarding, then reset mid-stream
    push(16'h20, 32'h1111_1111, 4'hF);
    push(16'h30, 32'h3333_3333, 4'hF);
    push(16'h20, 32'h0000_0022, 4'b0001);
    lookup(16'h20);
    idle();
    @(negedge clock);
    chk("t6_lookup_data", lookup_data, 32'h1111_1122);
    chk("t6_lookup_hit", lookup_hit, 1);
    do_reset();
    idle();
    @(negedge clock);
    chk("t6_count_after_reset", count, 0);

    // Random traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) < 6, 16'($urandom_range(0, 5)), $urandom,
              4'($urandom_range(1, 15)), $urandom_range(0, 9) < 7,
              16'($urandom_range(0, 5)), $urandom_range(0, 1) == 1);
      end
    end
    repeat (3) idle();
    @(negedge clock);
    if (dq.size() != 0) chk("leftover_drains", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
